// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Bundles every non-clock signal of the register-file write-back arbiter.
// The clock and reset are separate scalar ports on the arbiter itself.
//
// Signal groups:
//   req0_*          load unit write-back (valid/ready, addr, data)
//   req1_*          ALU write-back (valid/ready, addr, data)
//   issue_*         decode destination reservation (valid/ready, addr)
//   chk_rs*_addr    decode source registers to hazard-check
//   hazard_rs*      pending-write flags for those sources
//   rf_write_*      register file write port
//   idle            nothing pending and nothing in flight
//
// Modports:
//   slave   the arbiter side (drives ready, hazard, rf_write and idle)
//   master  the pipeline side (drives requests, issues and checks)
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);

   logic                      req0_valid;
   logic                      req0_ready;
   logic [REG_ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0]     req0_data;

   logic                      req1_valid;
   logic                      req1_ready;
   logic [REG_ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0]     req1_data;

   logic                      issue_valid;
   logic [REG_ADDR_WIDTH-1:0] issue_addr;
   logic                      issue_ready;

   logic [REG_ADDR_WIDTH-1:0] chk_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] chk_rs2_addr;
   logic                      hazard_rs1;
   logic                      hazard_rs2;

   logic                      rf_write_enable;
   logic [REG_ADDR_WIDTH-1:0] rf_write_addr;
   logic [DATA_WIDTH-1:0]     rf_write_data;

   logic                      idle;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  issue_valid, issue_addr,
      input  chk_rs1_addr, chk_rs2_addr,
      output req0_ready, req1_ready, issue_ready,
      output hazard_rs1, hazard_rs2,
      output rf_write_enable, rf_write_addr, rf_write_data,
      output idle
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output issue_valid, issue_addr,
      output chk_rs1_addr, chk_rs2_addr,
      input  req0_ready, req1_ready, issue_ready,
      input  hazard_rs1, hazard_rs2,
      input  rf_write_enable, rf_write_addr, rf_write_data,
      input  idle
   );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between the load unit (req0,
// high priority) and the ALU (req1). req1 is guaranteed service after
// MAX_WAIT consecutive lost cycles. The winning write-back is registered
// and presented to the register file one cycle later.
//
// A pending-write scoreboard (one bit per x1..x31) is set when decode
// issues a writer and cleared on the edge the register file is written,
// so decode can stall on RAW (hazard_rs*) and WAW (issue_ready) hazards.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   regfile_wb_arbiter_if.slave (requests, issue, checks, RF port)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MAX_WAIT       = 4    // legal range 1..7
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);

   localparam int         NUM_REGS   = 2 ** REG_ADDR_WIDTH;
   localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                      rf_we_q,    rf_we_d;
   logic [REG_ADDR_WIDTH-1:0] rf_addr_q,  rf_addr_d;
   logic [DATA_WIDTH-1:0]     rf_data_q,  rf_data_d;
   logic [NUM_REGS-1:1]       pending_q,  pending_d;
   logic [2:0]                wait_cnt_q, wait_cnt_d;

   // Full-width view with x0 tied to zero so every index is in range.
   logic [NUM_REGS-1:0]       pending_vec;
   assign pending_vec = {pending_q, 1'b0};

   // ------------------------------------------------------------------
   // Arbitration (combinational within the cycle)
   // ------------------------------------------------------------------
   logic                      force_req1;
   logic                      grant0;
   logic                      grant1;
   logic                      wb_handshake;
   logic [REG_ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0]     win_data;
   logic                      issue_handshake;

   // req1 overrides the fixed priority only once it has lost MAX_WAIT
   // cycles in a row.
   assign force_req1   = (wait_cnt_q == MAX_WAIT_C) && bus.req1_valid;
   assign grant0       = bus.req0_valid && !force_req1;
   assign grant1       = bus.req1_valid && !grant0;
   assign wb_handshake = grant0 || grant1;

   assign win_addr = grant0 ? bus.req0_addr : bus.req1_addr;
   assign win_data = grant0 ? bus.req0_data : bus.req1_data;

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   // ------------------------------------------------------------------
   // Hazard outputs (combinational from registered scoreboard only; a
   // clear on the coming edge is deliberately not forwarded, so hazards
   // drop exactly when the register file holds the new value)
   // ------------------------------------------------------------------
   assign bus.issue_ready = (bus.issue_addr == '0) || !pending_vec[bus.issue_addr];
   assign bus.hazard_rs1  = (bus.chk_rs1_addr != '0) && pending_vec[bus.chk_rs1_addr];
   assign bus.hazard_rs2  = (bus.chk_rs2_addr != '0) && pending_vec[bus.chk_rs2_addr];

   assign issue_handshake = bus.issue_valid && bus.issue_ready;

   assign bus.rf_write_enable = rf_we_q;
   assign bus.rf_write_addr   = rf_addr_q;
   assign bus.rf_write_data   = rf_data_q;
   assign bus.idle            = (pending_q == '0) && !rf_we_q;

   // ------------------------------------------------------------------
   // Write path next state
   // ------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      // A write-back to x0 completes its handshake but never reaches the RF.
      if (wb_handshake && (win_addr != '0)) begin
         rf_we_d   = 1'b1;
         rf_addr_d = win_addr;
         rf_data_d = win_data;
      end
   end

   // ------------------------------------------------------------------
   // Anti-starvation counter next state
   // ------------------------------------------------------------------
   always_comb begin
      wait_cnt_d = '0;
      if (bus.req1_valid && !grant1) begin
         wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 3'd1;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard next state
   // ------------------------------------------------------------------
   logic [NUM_REGS-1:0] pending_full_d;

   always_comb begin
      pending_full_d = pending_vec;
      // Clear on the edge the RF is written.
      if (rf_we_q) begin
         pending_full_d[rf_addr_q] = 1'b0;
      end
      // Set is applied last so a same-edge set of the same bit wins.
      if (issue_handshake && (bus.issue_addr != '0)) begin
         pending_full_d[bus.issue_addr] = 1'b1;
      end
      pending_full_d[0] = 1'b0;
      pending_d = pending_full_d[NUM_REGS-1:1];
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   // NOTE: the scoreboard is reset like any other flop; a stale pending
   // bit after reset would stall decode forever.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we_q    <= 1'b0;
         rf_addr_q  <= '0;
         rf_data_q  <= '0;
         pending_q  <= '0;
         wait_cnt_q <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_addr_q  <= rf_addr_d;
         rf_data_q  <= rf_data_d;
         pending_q  <= pending_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule
